// File: rtl/facto_master.sv
// Bus master that runs one factorial job on the memory-mapped factorial core
// and stores the 128-bit result into RAM as two consecutive 64-bit words.
module facto_master #(
  parameter logic [15:0] FACTO_BASE = 16'h7000,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [63:0]   operand,
  input  logic [15:0]   dst_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [127:0]  result,
  output logic          m_req,
  output logic          m_wr,
  output logic [15:0]   m_addr,
  output logic [63:0]   m_dout,
  input  logic          m_grant,
  input  logic [63:0]   m_din,
  input  logic          interrupt
);

  localparam logic [15:0] ADDR_OPSTART  = FACTO_BASE + 16'h0000;
  localparam logic [15:0] ADDR_OPCLEAR  = FACTO_BASE + 16'h0008;
  localparam logic [15:0] ADDR_INTREN   = FACTO_BASE + 16'h0018;
  localparam logic [15:0] ADDR_OPERAND  = FACTO_BASE + 16'h0020;
  localparam logic [15:0] ADDR_RESULT_H = FACTO_BASE + 16'h0028;
  localparam logic [15:0] ADDR_RESULT_L = FACTO_BASE + 16'h0030;

  typedef enum logic [3:0] {
    IDLE, REQ1, W_INTEN, W_OPND, W_START, WAIT_INT, REQ2, R_HI, C_HI,
    R_LO, C_LO, W_RAM_HI, W_RAM_LO, W_CLR, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [63:0]    operand_q, operand_d;
  logic [15:0]    dst_q, dst_d;
  logic [127:0]   result_q, result_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           timed_out_q, timed_out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           m_req_q, m_req_d;
  logic           m_wr_q, m_wr_d;
  logic [15:0]    m_addr_q, m_addr_d;
  logic [63:0]    m_dout_q, m_dout_d;

  // Next-state and captured-data logic; every bus state stalls while grant is low.
  always_comb begin
    state_d     = state_q;
    operand_d   = operand_q;
    dst_d       = dst_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    timed_out_d = timed_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d   = operand;
          dst_d       = dst_addr;
          err_d       = 1'b0;
          timed_out_d = 1'b0;
          cnt_d       = '0;
          state_d     = REQ1;
        end
      end
      REQ1:     if (m_grant) state_d = W_INTEN;
      W_INTEN:  if (m_grant) state_d = W_OPND;
      W_OPND:   if (m_grant) state_d = W_START;
      W_START: begin
        if (m_grant) begin
          cnt_d   = '0;
          state_d = WAIT_INT;
        end
      end
      WAIT_INT: begin
        cnt_d = cnt_q + 32'd1;
        if (interrupt) begin
          state_d = REQ2;
        end else if (cnt_q + 32'd1 == TIMEOUT) begin
          err_d       = 1'b1;
          timed_out_d = 1'b1;
          state_d     = REQ2;
        end
      end
      REQ2:     if (m_grant) state_d = timed_out_q ? W_CLR : R_HI;
      R_HI:     if (m_grant) state_d = C_HI;
      C_HI: begin
        if (m_grant) begin
          result_d[127:64] = m_din;
          state_d          = R_LO;
        end
      end
      R_LO:     if (m_grant) state_d = C_LO;
      C_LO: begin
        if (m_grant) begin
          result_d[63:0] = m_din;
          state_d        = W_RAM_HI;
        end
      end
      W_RAM_HI: if (m_grant) state_d = W_RAM_LO;
      W_RAM_LO: if (m_grant) state_d = W_CLR;
      W_CLR:    if (m_grant) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    m_req_d  = !(state_d inside {IDLE, WAIT_INT, DONE});
    m_wr_d   = 1'b0;
    m_addr_d = '0;
    m_dout_d = '0;
    case (state_d)
      W_INTEN: begin
        m_wr_d = 1'b1; m_addr_d = ADDR_INTREN;  m_dout_d = 64'h1;
      end
      W_OPND: begin
        m_wr_d = 1'b1; m_addr_d = ADDR_OPERAND; m_dout_d = operand_d;
      end
      W_START: begin
        m_wr_d = 1'b1; m_addr_d = ADDR_OPSTART; m_dout_d = 64'h1;
      end
      R_HI, C_HI: m_addr_d = ADDR_RESULT_H;
      R_LO, C_LO: m_addr_d = ADDR_RESULT_L;
      W_RAM_HI: begin
        m_wr_d = 1'b1; m_addr_d = dst_d;         m_dout_d = result_d[127:64];
      end
      W_RAM_LO: begin
        m_wr_d = 1'b1; m_addr_d = dst_d + 16'd1; m_dout_d = result_d[63:0];
      end
      W_CLR: begin
        m_wr_d = 1'b1; m_addr_d = ADDR_OPCLEAR; m_dout_d = 64'h1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      dst_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      timed_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      m_req_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_dout_q    <= '0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      dst_q       <= dst_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      timed_out_q <= timed_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      m_req_q     <= m_req_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_dout_q    <= m_dout_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign m_req  = m_req_q;
  assign m_wr   = m_wr_q;
  assign m_addr = m_addr_q;
  assign m_dout = m_dout_q;

endmodule

// File: doc/facto_master.md
FACTO_MASTER -- requirements
Module: facto_master

Interface
REQ-001 Parameter FACTO_BASE, default 16'h7000, base address of the factorial core register window.
REQ-002 Parameter TIMEOUT, default 4096, maximum cycles to wait for interrupt after opstart.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to compute; sampled only in IDLE.
REQ-006 operand  input  64  factorial operand, captured on accepted start.
REQ-007 dst_addr  input  16  RAM word address for the result, captured on accepted start.
REQ-008 busy  output  1  high from accepted start until DONE completes.
REQ-009 done  output  1  one-cycle pulse on job completion, success or error.
REQ-010 err  output  1  sticky timeout flag; cleared by next accepted start.
REQ-011 result  output  128  {result_h, result_l} of the last successful job.
REQ-012 m_req  output  1  bus request to the BUS arbiter.
REQ-013 m_wr  output  1  1 = write, 0 = read.
REQ-014 m_addr  output  16  bus address.
REQ-015 m_dout  output  64  bus write data.
REQ-016 m_grant  input  1  bus grant.
REQ-017 m_din  input  64  bus read data, valid the cycle after the read address cycle.
REQ-018 interrupt  input  1  factorial core completion interrupt, level.

Function
REQ-019 Register offsets from FACTO_BASE: opstart +0x00, opclear +0x08, intrEn +0x18, operand +0x20, result_h +0x28, result_l +0x30.
REQ-020 States: IDLE, REQ1, W_INTEN, W_OPND, W_START, WAIT_INT, REQ2, R_HI, C_HI, R_LO, C_LO, W_RAM_HI, W_RAM_LO, W_CLR, DONE.
REQ-021 IDLE: start=1 captures operand/dst_addr, clears err, goes to REQ1; start outside IDLE is ignored.
REQ-022 REQ1/REQ2: m_req=1, m_wr=0; advance only when m_grant=1.
REQ-023 m_req stays 1 in every state from REQ1 to W_START and from REQ2 to W_CLR; 0 in IDLE, WAIT_INT, DONE.
REQ-024 Bus transfers occur only while m_grant=1; grant loss mid-sequence stalls in the current state with outputs held until regrant.
REQ-025 W_INTEN writes 64'h1 to intrEn; W_OPND writes operand to operand; W_START writes 64'h1 to opstart; one cycle each.
REQ-026 WAIT_INT: m_req=0; counter increments each cycle; interrupt=1 goes to REQ2; counter reaching TIMEOUT sets err and goes to W_CLR via REQ2 with reads skipped.
REQ-027 R_HI reads result_h, C_HI captures m_din into result[127:64]; R_LO/C_LO same for result_l into result[63:0].
REQ-028 W_RAM_HI writes result_h to dst_addr; W_RAM_LO writes result_l to dst_addr+1, 16-bit wrap (16'hFFFF+1 = 16'h0000).
REQ-029 W_CLR writes 64'h1 to opclear, deasserting interrupt; then DONE.
REQ-030 DONE: done=1 one cycle, busy=0 next cycle, return to IDLE.
REQ-031 On timeout, result holds its previous value and RAM is not written.
REQ-032 Outside write states m_wr=0, m_dout=0; outside bus states m_addr=0.
REQ-033 interrupt=1 while in IDLE is ignored.
REQ-034 Total latency, grant always 1, no timeout: 12 cycles plus WAIT_INT residency from start to done.

Reset
REQ-035 reset_n=0 forces IDLE asynchronously: busy, done, err, m_req, m_wr = 0; m_addr, m_dout = 0; result = 0; counter = 0.
REQ-036 Reset mid-job abandons it without bus cleanup; no done pulse is generated.

Verification
REQ-037 operand=5, dst_addr=16'h0010, real Top -> done after interrupt; result=128'd120; RAM[0x10]=0, RAM[0x11]=120; err=0.
REQ-038 operand=0 and operand=1 -> result=128'd1 both cases.
REQ-039 m_grant forced low 3 cycles during W_OPND -> state and bus outputs held, sequence resumes, result correct.
REQ-040 interrupt never asserted, TIMEOUT=16 -> err=1 and done after 16 WAIT_INT cycles; opclear written; RAM unchanged; result unchanged.
REQ-041 dst_addr=16'hFFFF -> result_h at 0xFFFF, result_l at 0x0000.
REQ-042 reset_n pulsed low in WAIT_INT -> immediate IDLE, all outputs 0; new start afterward completes normally.
